// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and saturating-add helper for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DISPENSE = 2'b01,
        RELEASE  = 2'b10,
        CANCEL   = 2'b11
    } state_t;

    // Operands are zero-extended by the caller; the result never exceeds max_val.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/vend_inventory.sv
// rtl/vend_inventory.sv - per-slot stock registers with saturating restock, decrement and two read ports
module vend_inventory
    import vend_pkg::*;
#(
    parameter int NUM_SLOTS  = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 5,
    parameter int IDX_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_en,
    input  logic [IDX_W-1:0]   dec_index,
    input  logic               restock_valid,
    input  logic [IDX_W-1:0]   restock_index,
    input  logic [STOCK_W-1:0] restock_count,
    input  logic [IDX_W-1:0]   rd_index,
    output logic [STOCK_W-1:0] rd_level,
    input  logic [IDX_W-1:0]   sel_index,
    output logic [STOCK_W-1:0] sel_level
);

    localparam logic [31:0] STOCK_MAX = (32'd1 << STOCK_W) - 32'd1;

    logic [STOCK_W-1:0] level [NUM_SLOTS];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        logic [STOCK_W-1:0] slot_q;
        logic [STOCK_W-1:0] slot_d;
        logic [STOCK_W-1:0] base;
        logic [STOCK_W-1:0] add;

        // Decrement first, then saturating add: a same-cycle sale and restock
        // never lose the sale even when the slot was already full.
        always_comb begin
            base = slot_q;
            add  = '0;
            if (dec_en && (dec_index == IDX_W'(g))) begin
                base = slot_q - STOCK_W'(1);
            end
            if (restock_valid && (restock_index == IDX_W'(g))) begin
                add = restock_count;
            end
            slot_d = STOCK_W'(sat_add(32'(base), 32'(add), STOCK_MAX));
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q <= STOCK_W'(INIT_STOCK);
            end else begin
                slot_q <= slot_d;
            end
        end

        assign level[g] = slot_q;
    end

    always_comb begin
        rd_level = '0;
        if (32'(rd_index) < 32'(NUM_SLOTS)) begin
            rd_level = level[rd_index];
        end
    end

    always_comb begin
        sel_level = '0;
        if (32'(sel_index) < 32'(NUM_SLOTS)) begin
            sel_level = level[sel_index];
        end
    end

endmodule

// File: rtl/vend_multi_slot_ctrl.sv
// rtl/vend_multi_slot_ctrl.sv - vending session FSM with timeout and 4-phase dispense/refund handshakes
// Optional sales counter output enabled by VEND_SALES_CNT_EN.
module vend_multi_slot_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_SLOTS      = 8,
    parameter int STOCK_W        = 4,
    parameter int INIT_STOCK     = 5,
    parameter int TIMEOUT_CYCLES = 40,
    localparam int IDX_W         = ($clog2(NUM_SLOTS) > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel_valid,
    input  logic [IDX_W-1:0]   sel_index,
    input  logic               cancel,
    output logic               disp_req,
    output logic [IDX_W-1:0]   disp_index,
    input  logic               disp_ack,
    output logic               cancel_req,
    input  logic               cancel_ack,
    input  logic               restock_valid,
    input  logic [IDX_W-1:0]   restock_index,
    input  logic [STOCK_W-1:0] restock_count,
    input  logic [IDX_W-1:0]   rd_index,
    output logic [STOCK_W-1:0] rd_level,
    output logic [1:0]         state,
    output logic               out_of_stock
`ifdef VEND_SALES_CNT_EN
    ,
    output logic [15:0]        sales_count
`endif
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic [IDX_W-1:0]   disp_index_q, disp_index_d;
    logic               oos_q, oos_d;
    logic               dec_en;
    logic [STOCK_W-1:0] sel_level;
    logic               sel_ok;

    vend_inventory #(
        .NUM_SLOTS  (NUM_SLOTS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK),
        .IDX_W      (IDX_W)
    ) u_inventory (
        .clk           (clk),
        .rst           (rst),
        .dec_en        (dec_en),
        .dec_index     (disp_index_q),
        .restock_valid (restock_valid),
        .restock_index (restock_index),
        .restock_count (restock_count),
        .rd_index      (rd_index),
        .rd_level      (rd_level),
        .sel_index     (sel_index),
        .sel_level     (sel_level)
    );

    assign sel_ok = (32'(sel_index) < 32'(NUM_SLOTS)) && (sel_level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            disp_index_q <= '0;
            oos_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            disp_index_q <= disp_index_d;
            oos_q        <= oos_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        disp_index_d = disp_index_q;
        oos_d        = 1'b0;
        dec_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    if (sel_ok) begin
                        disp_index_d = sel_index;
                        cnt_d        = '0;
                        state_d      = DISPENSE;
                    end else begin
                        oos_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                // Acknowledge takes priority over a coincident cancel or timeout.
                if (disp_ack) begin
                    dec_en  = 1'b1;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (cancel || (cnt_q == CNT_LAST)) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = CANCEL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!disp_ack) begin
                    state_d = IDLE;
                end
            end
            CANCEL: begin
                if (!phase_q) begin
                    if (cancel_ack) begin
                        phase_d = 1'b1;
                    end
                end else if (!cancel_ack) begin
                    phase_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Requests decode straight from registered state so reset drops them asynchronously.
    assign disp_req     = (state_q == DISPENSE);
    assign cancel_req   = (state_q == CANCEL) && !phase_q;
    assign disp_index   = disp_index_q;
    assign state        = state_q;
    assign out_of_stock = oos_q;

`ifdef VEND_SALES_CNT_EN
    logic [15:0] sales_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sales_q <= '0;
        end else if (dec_en && (sales_q != 16'hFFFF)) begin
            sales_q <= sales_q + 16'd1;
        end
    end

    assign sales_count = sales_q;
`endif

endmodule

// File: tb/tb_vend_multi_slot_ctrl.sv
// tb/tb_vend_multi_slot_ctrl.sv - table-driven and sequence checks for vend_multi_slot_ctrl
module tb_vend_multi_slot_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_valid;
    logic [2:0] sel_index;
    logic       cancel;
    logic       disp_req;
    logic [2:0] disp_index;
    logic       disp_ack;
    logic       cancel_req;
    logic       cancel_ack;
    logic       restock_valid;
    logic [2:0] restock_index;
    logic [3:0] restock_count;
    logic [2:0] rd_index;
    logic [3:0] rd_level;
    logic [1:0] state;
    logic       out_of_stock;
`ifdef VEND_SALES_CNT_EN
    logic [15:0] sales_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int sv, si, cn, da, ca, rv, ri, rc, rdi;
        int e_state, e_req, e_creq, e_oos, e_didx, e_rd;
    } vec_t;

    vec_t vecs[$];

    vend_multi_slot_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .sel_valid     (sel_valid),
        .sel_index     (sel_index),
        .cancel        (cancel),
        .disp_req      (disp_req),
        .disp_index    (disp_index),
        .disp_ack      (disp_ack),
        .cancel_req    (cancel_req),
        .cancel_ack    (cancel_ack),
        .restock_valid (restock_valid),
        .restock_index (restock_index),
        .restock_count (restock_count),
        .rd_index      (rd_index),
        .rd_level      (rd_level),
        .state         (state),
        .out_of_stock  (out_of_stock)
`ifdef VEND_SALES_CNT_EN
        ,
        .sales_count   (sales_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        sel_valid = 0; sel_index = 0; cancel = 0; disp_ack = 0; cancel_ack = 0;
        restock_valid = 0; restock_index = 0; restock_count = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispense(input int idx);
        sel_valid = 1; sel_index = idx[2:0];
        tick();
        sel_valid = 0;
        chk("disp_req_after_sel", int'(disp_req), 1);
        disp_ack = 1;
        tick();
        disp_ack = 0;
        tick();
        chk("state_after_dispense", int'(state), 0);
    endtask

    initial begin
        int n;
        vec_t v;
        rst = 1;
        idle_inputs();
        rd_index = 0;

        // {sv,si,cn,da,ca,rv,ri,rc,rdi, e_state,e_req,e_creq,e_oos,e_didx,e_rd}
        vecs.push_back('{0,0,0,0,0,0,0,0,2, 0,0,0,0,0,5});
        vecs.push_back('{1,2,0,0,0,0,0,0,2, 1,1,0,0,2,5});
        vecs.push_back('{0,0,0,0,0,0,0,0,2, 1,1,0,0,2,5});
        vecs.push_back('{0,0,0,1,0,0,0,0,2, 2,0,0,0,0,4});
        vecs.push_back('{0,0,0,1,0,0,0,0,2, 2,0,0,0,0,4});
        vecs.push_back('{0,0,0,0,0,0,0,0,2, 0,0,0,0,0,4});
        vecs.push_back('{1,7,0,0,0,0,0,0,7, 1,1,0,0,7,5});
        vecs.push_back('{0,0,1,1,0,0,0,0,7, 2,0,0,0,0,4});
        vecs.push_back('{0,0,0,0,0,0,0,0,7, 0,0,0,0,0,4});
        vecs.push_back('{0,0,1,0,0,0,0,0,7, 0,0,0,0,0,4});
        vecs.push_back('{1,3,0,0,0,0,0,0,3, 1,1,0,0,3,5});
        vecs.push_back('{0,0,0,1,0,1,3,2,3, 2,0,0,0,0,6});
        vecs.push_back('{0,0,0,0,0,0,0,0,3, 0,0,0,0,0,6});
        vecs.push_back('{0,0,0,0,0,1,3,15,3, 0,0,0,0,0,15});
        vecs.push_back('{1,5,1,0,0,0,0,0,5, 1,1,0,0,5,5});
        vecs.push_back('{0,0,1,0,0,0,0,0,5, 3,0,1,0,0,5});
        vecs.push_back('{1,0,0,0,0,0,0,0,5, 3,0,1,0,0,5});
        vecs.push_back('{0,0,0,0,1,0,0,0,5, 3,0,0,0,0,5});
        vecs.push_back('{0,0,0,0,1,0,0,0,5, 3,0,0,0,0,5});
        vecs.push_back('{0,0,0,0,0,0,0,0,5, 0,0,0,0,0,5});
        vecs.push_back('{0,0,0,0,0,1,6,3,6, 0,0,0,0,0,8});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state_async", int'(state), 0);
        rst = 0;
        tick();
        chk("reset_state", int'(state), 0);
        chk("reset_disp_req", int'(disp_req), 0);
        chk("reset_cancel_req", int'(cancel_req), 0);
        chk("reset_oos", int'(out_of_stock), 0);
        chk("reset_disp_index", int'(disp_index), 0);
        for (int i = 0; i < 8; i++) begin
            rd_index = i[2:0];
            #1;
            chk($sformatf("reset_rd_level_%0d", i), int'(rd_level), 5);
        end
`ifdef VEND_SALES_CNT_EN
        chk("reset_sales", int'(sales_count), 0);
`endif

        foreach (vecs[k]) begin
            v = vecs[k];
            sel_valid = v.sv[0]; sel_index = v.si[2:0]; cancel = v.cn[0];
            disp_ack = v.da[0]; cancel_ack = v.ca[0];
            restock_valid = v.rv[0]; restock_index = v.ri[2:0]; restock_count = v.rc[3:0];
            rd_index = v.rdi[2:0];
            tick();
            chk($sformatf("vec%0d_state", k), int'(state), v.e_state);
            chk($sformatf("vec%0d_disp_req", k), int'(disp_req), v.e_req);
            chk($sformatf("vec%0d_cancel_req", k), int'(cancel_req), v.e_creq);
            chk($sformatf("vec%0d_oos", k), int'(out_of_stock), v.e_oos);
            chk($sformatf("vec%0d_rd_level", k), int'(rd_level), v.e_rd);
            if (v.e_req != 0) chk($sformatf("vec%0d_disp_index", k), int'(disp_index), v.e_didx);
        end
        idle_inputs();
        tick();

        // Drain slot 0, then a sixth select is rejected with a one-cycle pulse.
        for (int i = 0; i < 5; i++) dispense(0);
        rd_index = 0;
        sel_valid = 1; sel_index = 0;
        tick();
        sel_valid = 0;
        chk("empty_oos_pulse", int'(out_of_stock), 1);
        chk("empty_state", int'(state), 0);
        chk("empty_rd_level", int'(rd_level), 0);
        tick();
        chk("empty_oos_cleared", int'(out_of_stock), 0);
        chk("empty_state_after", int'(state), 0);

        // Timeout: disp_req must stay high for exactly 40 cycles.
        rd_index = 1;
        sel_valid = 1; sel_index = 1;
        tick();
        sel_valid = 0;
        n = 0;
        while (disp_req && n < 100) begin
            n++;
            tick();
        end
        chk("timeout_req_cycles", n, 40);
        chk("timeout_cancel_req", int'(cancel_req), 1);
        chk("timeout_state", int'(state), 3);
        cancel_ack = 1;
        tick();
        chk("timeout_creq_drop", int'(cancel_req), 0);
        cancel_ack = 0;
        tick();
        chk("timeout_idle", int'(state), 0);
        chk("timeout_stock_kept", int'(rd_level), 5);

`ifdef VEND_SALES_CNT_EN
        // Three from the vector table plus five on slot 0; the timeout adds none.
        chk("sales_count", int'(sales_count), 8);
`endif

        // Reset in the middle of a refund handshake.
        sel_valid = 1; sel_index = 4;
        tick();
        sel_valid = 0; cancel = 1;
        tick();
        cancel = 0;
        chk("pre_reset_cancel_req", int'(cancel_req), 1);
        #2 rst = 1;
        #1;
        chk("async_reset_cancel_req", int'(cancel_req), 0);
        chk("async_reset_state", int'(state), 0);
`ifdef VEND_SALES_CNT_EN
        chk("async_reset_sales", int'(sales_count), 0);
`endif
        tick();
        rst = 0;
        rd_index = 0;
        tick();
        chk("post_reset_stock0", int'(rd_level), 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
